// File: rtl/rf_writeback_arbiter_if.sv
// Result-collection and RF write-port bundle for the write-side front end of the register file.
// The master side is the producers plus the register file. The slave side is the arbiter.
interface rf_writeback_arbiter_if #(
   parameter int WORD_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 3,
   parameter int SOURCES       = 4,
   parameter int WRITE_PORTS   = 2
);
   logic [SOURCES-1:0]                        src_valid_i;
   logic [SOURCES-1:0]                        src_ready_o;
   logic [SOURCES-1:0][ADDRESS_WIDTH-1:0]     src_addr_i;
   logic [SOURCES-1:0][WORD_WIDTH-1:0]        src_data_i;
   logic [WRITE_PORTS-1:0][ADDRESS_WIDTH-1:0] select_r_o;
   logic [WRITE_PORTS-1:0][WORD_WIDTH-1:0]    data_o;
   logic [WRITE_PORTS-1:0]                    enable_writing_o;

   modport master (
      output src_valid_i, src_addr_i, src_data_i,
      input  src_ready_o, select_r_o, data_o, enable_writing_o
   );

   modport slave (
      input  src_valid_i, src_addr_i, src_data_i,
      output src_ready_o, select_r_o, data_o, enable_writing_o
   );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Per-source result FIFOs feeding a round-robin, address-conflict-free arbiter
// that drives WRITE_PORTS registered register-file write ports.
module rf_writeback_arbiter #(
   parameter int WORD_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 3,
   parameter int SOURCES       = 4,
   parameter int WRITE_PORTS   = 2,
   parameter int DEPTH         = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   rf_writeback_arbiter_if.slave wb,
   output logic                 idle_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int SRC_W = (SOURCES > 1) ? $clog2(SOURCES) : 1;

   logic [SOURCES-1:0][DEPTH-1:0][ADDRESS_WIDTH-1:0] fifo_addr;
   logic [SOURCES-1:0][DEPTH-1:0][WORD_WIDTH-1:0]    fifo_data;
   logic [SOURCES-1:0][PTR_W-1:0]                    rd_ptr;
   logic [SOURCES-1:0][PTR_W-1:0]                    wr_ptr;
   logic [SOURCES-1:0][CNT_W-1:0]                    count;
   logic [SOURCES-1:0][CNT_W-1:0]                    count_next;
   logic [SRC_W-1:0]                                 rr_ptr;
   logic [SRC_W-1:0]                                 rr_next;
   logic [SOURCES-1:0]                               ready;
   logic [SOURCES-1:0]                               push;
   logic [SOURCES-1:0]                               pop;
   logic [WRITE_PORTS-1:0]                           grant_en;
   logic [WRITE_PORTS-1:0][ADDRESS_WIDTH-1:0]        grant_addr;
   logic [WRITE_PORTS-1:0][WORD_WIDTH-1:0]           grant_data;

   // Ready depends only on registered occupancy, so a full FIFO never takes a same-cycle bypass.
   always_comb begin
      ready = '0;
      push  = '0;
      for (int s = 0; s < SOURCES; s++) begin
         ready[s] = (count[s] < CNT_W'(DEPTH)) && !rst_i;
         push[s]  = wb.src_valid_i[s] && ready[s];
      end
   end

   assign wb.src_ready_o = ready;

   // Scan heads from rr_ptr; a head whose address is already granted this cycle waits in place.
   always_comb begin
      logic [SRC_W-1:0] s;
      logic             clash;
      int               n;
      pop        = '0;
      grant_en   = '0;
      grant_addr = '0;
      grant_data = '0;
      rr_next    = rr_ptr;
      s          = '0;
      clash      = 1'b0;
      n          = 0;
      for (int i = 0; i < SOURCES; i++) begin
         s = SRC_W'((int'(rr_ptr) + i) % SOURCES);
         if (count[s] != '0 && n < WRITE_PORTS) begin
            clash = 1'b0;
            for (int k = 0; k < WRITE_PORTS; k++) begin
               if (k < n && grant_addr[k] == fifo_addr[s][rd_ptr[s]]) clash = 1'b1;
            end
            if (!clash) begin
               for (int k = 0; k < WRITE_PORTS; k++) begin
                  if (k == n) begin
                     grant_en[k]   = 1'b1;
                     grant_addr[k] = fifo_addr[s][rd_ptr[s]];
                     grant_data[k] = fifo_data[s][rd_ptr[s]];
                  end
               end
               pop[s]  = 1'b1;
               n       = n + 1;
               rr_next = (s == SRC_W'(SOURCES - 1)) ? '0 : s + SRC_W'(1);
            end
         end
      end
   end

   always_comb begin
      count_next = count;
      for (int s = 0; s < SOURCES; s++) begin
         case ({push[s], pop[s]})
            2'b10:   count_next[s] = count[s] + CNT_W'(1);
            2'b01:   count_next[s] = count[s] - CNT_W'(1);
            default: count_next[s] = count[s];
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      for (int s = 0; s < SOURCES; s++) begin
         if (push[s]) begin
            fifo_addr[s][wr_ptr[s]] <= wb.src_addr_i[s];
            fifo_data[s][wr_ptr[s]] <= wb.src_data_i[s];
         end
      end
   end

   // Output register stage: granted heads leave the FIFOs and appear on the write ports.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr              <= '0;
         wr_ptr              <= '0;
         count               <= '0;
         rr_ptr              <= '0;
         wb.enable_writing_o <= '0;
         wb.select_r_o       <= '0;
         wb.data_o           <= '0;
         idle_o              <= 1'b1;
      end else begin
         for (int s = 0; s < SOURCES; s++) begin
            if (push[s]) wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
            if (pop[s])  rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
         end
         count               <= count_next;
         rr_ptr              <= rr_next;
         wb.enable_writing_o <= grant_en;
         wb.select_r_o       <= grant_addr;
         wb.data_o           <= grant_data;
         idle_o              <= (count_next == '0) && (grant_en == '0);
      end
   end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed and random stimulus against a queue-based reference model of the writeback arbiter.
module tb_rf_writeback_arbiter;
   localparam int WW = 8;
   localparam int AW = 3;
   localparam int NS = 4;
   localparam int WP = 2;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   logic rst;
   logic idle;

   rf_writeback_arbiter_if #(.WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .SOURCES(NS), .WRITE_PORTS(WP)) bus ();

   rf_writeback_arbiter #(
      .WORD_WIDTH(WW), .ADDRESS_WIDTH(AW), .SOURCES(NS), .WRITE_PORTS(WP), .DEPTH(DEPTH)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .wb    (bus),
      .idle_o(idle)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [WW-1:0] d;
   } ent_t;

   ent_t                    mq[NS][$];
   int                      m_rr;
   logic [WP-1:0]           exp_en;
   logic [WP-1:0][AW-1:0]   exp_sel;
   logic [WP-1:0][WW-1:0]   exp_dat;
   logic                    exp_idle;
   logic [WW-1:0]           m_rf[8];
   logic [WW-1:0]           d_rf[8];
   logic                    pv[NS];
   ent_t                    pe[NS];
   int                      total = 0;
   int                      bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic offer(input int s, input logic [AW-1:0] a, input logic [WW-1:0] d);
      pv[s] = 1'b1;
      pe[s] = {a, d};
   endtask

   // Offer a new random result on every idle source; addresses carry the source id when distinct.
   task automatic offer_random(input bit distinct, input int pct);
      for (int s = 0; s < NS; s++) begin
         if (!pv[s] && $urandom_range(99) < pct) begin
            if (distinct) offer(s, {1'($urandom_range(1)), 2'(s)}, 8'($urandom));
            else          offer(s, 3'($urandom), 8'($urandom));
         end
      end
   endtask

   // One clock: drive held offers, compare outputs mid-cycle, advance the model across the edge.
   task automatic cycle();
      ent_t          g[$];
      int            gsrc[$];
      logic [NS-1:0] exp_rdy;
      logic [NS-1:0] acc;
      logic          dup;
      logic          clash;
      bit            empty;
      int            s;
      for (int i = 0; i < NS; i++) begin
         bus.src_valid_i[i] = pv[i];
         bus.src_addr_i[i]  = pe[i].a;
         bus.src_data_i[i]  = pe[i].d;
      end
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
         exp_rdy[i] = !rst && (mq[i].size() < DEPTH);
         acc[i]     = exp_rdy[i] && pv[i];
      end
      dup = 1'b0;
      for (int j = 0; j < WP; j++)
         for (int k = j + 1; k < WP; k++)
            if (bus.enable_writing_o[j] && bus.enable_writing_o[k] &&
                bus.select_r_o[j] == bus.select_r_o[k]) dup = 1'b1;
      check("ready", 32'(bus.src_ready_o), 32'(exp_rdy));
      check("enable", 32'(bus.enable_writing_o), 32'(exp_en));
      check("select", 32'(bus.select_r_o), 32'(exp_sel));
      check("data", 32'(bus.data_o), 32'(exp_dat));
      check("idle", 32'(idle), 32'(exp_idle));
      check("same_cycle_dup_addr", 32'(dup), 32'd0);
      for (int k = 0; k < WP; k++)
         if (bus.enable_writing_o[k] === 1'b1) d_rf[bus.select_r_o[k]] = bus.data_o[k];

      for (int i = 0; i < NS; i++) begin
         s = (m_rr + i) % NS;
         if (mq[s].size() != 0 && g.size() < WP) begin
            clash = 1'b0;
            foreach (g[j]) if (g[j].a == mq[s][0].a) clash = 1'b1;
            if (!clash) begin
               g.push_back(mq[s][0]);
               gsrc.push_back(s);
            end
         end
      end
      exp_en  = '0;
      exp_sel = '0;
      exp_dat = '0;
      if (rst) begin
         for (int i = 0; i < NS; i++) mq[i].delete();
         m_rr     = 0;
         exp_idle = 1'b1;
      end else begin
         foreach (gsrc[j]) void'(mq[gsrc[j]].pop_front());
         for (int i = 0; i < NS; i++) if (acc[i]) mq[i].push_back(pe[i]);
         foreach (g[j]) begin
            exp_en[j]    = 1'b1;
            exp_sel[j]   = g[j].a;
            exp_dat[j]   = g[j].d;
            m_rf[g[j].a] = g[j].d;
         end
         if (gsrc.size() > 0) m_rr = (gsrc[gsrc.size() - 1] + 1) % NS;
         empty = 1'b1;
         for (int i = 0; i < NS; i++) if (mq[i].size() != 0) empty = 1'b0;
         exp_idle = empty && (g.size() == 0);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) if (acc[i]) pv[i] = 1'b0;
   endtask

   task automatic do_reset();
      for (int i = 0; i < NS; i++) pv[i] = 1'b0;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      ent_t s1_list[3];
      int   s1_idx;
      rst = 1'b1;
      for (int i = 0; i < NS; i++) begin
         pv[i] = 1'b0;
         pe[i] = '0;
      end
      for (int r = 0; r < 8; r++) begin
         m_rf[r] = '0;
         d_rf[r] = '0;
      end
      m_rr     = 0;
      exp_en   = '0;
      exp_sel  = '0;
      exp_dat  = '0;
      exp_idle = 1'b1;
      bus.src_valid_i = '0;
      bus.src_addr_i  = '0;
      bus.src_data_i  = '0;
      @(posedge clk);
      #1;
      do_reset();

      // Single uncontended write.
      offer(0, 3'd3, 8'h5A);
      cycle();
      cycle();
      check("t1_en", 32'(bus.enable_writing_o), 32'b01);
      check("t1_sel", 32'(bus.select_r_o[0]), 32'd3);
      check("t1_data", 32'(bus.data_o[0]), 32'h5A);
      check("t1_idle_busy", 32'(idle), 32'd0);
      cycle();
      check("t1_en_off", 32'(bus.enable_writing_o), 32'b00);
      check("t1_idle_back", 32'(idle), 32'd1);

      // Four sources at once with rr_ptr at 0.
      do_reset();
      offer(0, 3'd1, 8'h11);
      offer(1, 3'd2, 8'h22);
      offer(2, 3'd4, 8'h44);
      offer(3, 3'd5, 8'h55);
      cycle();
      cycle();
      check("t2_a_en", 32'(bus.enable_writing_o), 32'b11);
      check("t2_a_sel", 32'(bus.select_r_o), 32'({3'd2, 3'd1}));
      check("t2_a_data", 32'(bus.data_o), 32'({8'h22, 8'h11}));
      cycle();
      check("t2_b_sel", 32'(bus.select_r_o), 32'({3'd5, 3'd4}));
      check("t2_b_data", 32'(bus.data_o), 32'({8'h55, 8'h44}));

      // Same destination from two sources: the second waits one cycle.
      offer(0, 3'd6, 8'hAA);
      offer(2, 3'd6, 8'hBB);
      cycle();
      cycle();
      check("t3_first_en", 32'(bus.enable_writing_o), 32'b01);
      check("t3_first", 32'({bus.select_r_o[0], bus.data_o[0]}), 32'({3'd6, 8'hAA}));
      cycle();
      check("t3_second_en", 32'(bus.enable_writing_o), 32'b01);
      check("t3_second", 32'({bus.select_r_o[0], bus.data_o[0]}), 32'({3'd6, 8'hBB}));
      cycle();
      check("t3_reg6", 32'(d_rf[6]), 32'hBB);

      // src1 streams three results while the other sources keep the ports busy.
      s1_list[0] = {3'b001, 8'hA1};
      s1_list[1] = {3'b101, 8'hA2};
      s1_list[2] = {3'b001, 8'hA3};
      s1_idx = 0;
      for (int c = 0; c < 14; c++) begin
         if (!pv[1] && s1_idx < 3) begin
            offer(1, s1_list[s1_idx].a, s1_list[s1_idx].d);
            s1_idx++;
         end
         for (int s = 0; s < NS; s++)
            if (s != 1 && !pv[s]) offer(s, {1'($urandom_range(1)), 2'(s)}, 8'($urandom));
         cycle();
      end

      // Reset in the middle of a full stream.
      for (int c = 0; c < 6; c++) begin
         offer_random(1'b1, 100);
         cycle();
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("t5_en_cleared", 32'(bus.enable_writing_o), 32'b00);
      check("t5_idle", 32'(idle), 32'd1);

      // Saturated load on all sources with source-distinct addresses.
      for (int c = 0; c < 100; c++) begin
         offer_random(1'b1, 100);
         cycle();
         if (c >= 4) check("t6_two_writes", 32'($countones(bus.enable_writing_o)), 32'd2);
      end

      // Random load with arbitrary, frequently colliding addresses.
      for (int c = 0; c < 150; c++) begin
         offer_random(1'b0, 50);
         cycle();
      end

      for (int c = 0; c < 20; c++) cycle();
      check("drain_idle", 32'(idle), 32'd1);
      for (int r = 0; r < 8; r++) check("rf_final", 32'(d_rf[r]), 32'(m_rf[r]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
